// File: rtl/direction_input_queue_pkg.sv
// direction_input_queue_pkg: direction codes and helpers shared by the input queue
package direction_input_queue_pkg;
  typedef enum logic [1:0] {TOP_DIR = 2'b00, RIGHT_DIR = 2'b01, DOWN_DIR = 2'b10, LEFT_DIR = 2'b11} dir_t;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction
endpackage

// File: rtl/direction_input_queue_debounce.sv
// button_debounce: two-flop synchroniser, stability counter and debounced rising-edge pulse
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);
  logic [1:0] sync;
  logic state;
  logic flip;
  logic [CNT_W-1:0] cnt;
  // level/rise show the post-edge state so the top can act on the flip in the same edge
  always_comb begin
    flip = (sync[1] != state) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    level = state ^ flip;
    rise = flip & ~state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      state <= 1'b0;
      cnt <= '0;
    end else begin
      sync <= {sync[0], raw};
      state <= level;
      cnt <= (sync[1] == state || flip) ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/direction_input_queue.sv
// direction_input_queue: debounced buttons to validated direction requests, released one per tick
module direction_input_queue
  import direction_input_queue_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int QUEUE_DEPTH = 4,
  parameter dir_t INIT_DIR = TOP_DIR
) (
  input  logic clk,
  input  logic reset,
  input  logic left,
  input  logic right,
  input  logic up,
  input  logic down,
  input  logic tick,
  output dir_t dir,
  output logic dir_changed,
  output logic reject,
  output logic overflow,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  logic [3:0] btn, level, rise;
  dir_t fifo [QUEUE_DEPTH];
  logic [PTR_W-1:0] rd, wr;
  dir_t cand, ref_dir;
  logic valid, bad, accept, full, pop, push, rej, ovf;
  // bit index equals the direction code
  assign btn = {left, down, right, up};
  for (genvar g = 0; g < 4; g++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk(clk), .reset(reset), .raw(btn[g]), .level(level[g]), .rise(rise[g])
    );
  end
  always_comb begin
    cand = rise[1] ? RIGHT_DIR : rise[2] ? DOWN_DIR : rise[3] ? LEFT_DIR : TOP_DIR;
    ref_dir = (queue_count != '0) ? fifo[wr - 1'b1] : dir;
    valid = $onehot(rise) && $onehot(level);
    bad = (cand == ref_dir) || (cand == opposite(ref_dir));
    accept = valid && !bad;
    rej = (|rise) && !accept;
    full = queue_count == CW'(QUEUE_DEPTH);
    pop = tick && (queue_count != '0);
    push = accept && (!full || pop);
    ovf = accept && full && !pop;
  end
  always_ff @(posedge clk) begin
    if (push) fifo[wr] <= cand;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd <= '0;
      wr <= '0;
      queue_count <= '0;
      dir <= INIT_DIR;
      dir_changed <= 1'b0;
      reject <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) begin
        rd <= rd + 1'b1;
        dir <= fifo[rd];
      end
      queue_count <= queue_count + CW'(push) - CW'(pop);
      dir_changed <= pop;
      reject <= rej;
      overflow <= ovf;
    end
  end
endmodule

// File: tb/tb_direction_input_queue.sv
// tb_direction_input_queue: directed stimulus with an event scoreboard for the direction queue
module tb_direction_input_queue;
  import direction_input_queue_pkg::*;
  logic clk = 0, reset = 1, left = 0, right = 0, up = 0, down = 0, tick = 0;
  dir_t dir;
  logic dir_changed, reject, overflow;
  logic [2:0] queue_count;
  int n_cmp = 0, n_err = 0;
  typedef struct {int kind; int d;} ev_t;
  ev_t exp_q[$];

  direction_input_queue dut (
    .clk(clk), .reset(reset), .left(left), .right(right), .up(up), .down(down), .tick(tick),
    .dir(dir), .dir_changed(dir_changed), .reject(reject), .overflow(overflow), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int d);
    exp_q.push_back('{kind, d});
  endtask

  task automatic chk_ev(input int kind, input int d);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind %0d dir %0d expected none", kind, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == 0 && e.d != d)) begin
        n_err++;
        $display("FAIL event: got kind %0d dir %0d expected kind %0d dir %0d", kind, d, e.kind, e.d);
      end
    end
  endtask

  // monitor: kind 0 = dir_changed, 1 = reject, 2 = overflow
  always @(negedge clk) begin
    if (dir_changed) chk_ev(0, int'(dir));
    if (reject) chk_ev(1, 0);
    if (overflow) chk_ev(2, 0);
  end

  task automatic do_reset();
    reset = 1;
    step(2);
    reset = 0;
  endtask

  task automatic press(input logic [3:0] m);
    {left, down, right, up} = m;
    step(10);
    {left, down, right, up} = 4'b0;
    step(8);
  endtask

  task automatic pulse_tick();
    tick = 1;
    step(1);
    tick = 0;
    step(1);
  endtask

  initial begin
    do_reset();
    chk("reset_dir", int'(dir), 0);
    chk("reset_count", int'(queue_count), 0);
    chk("reset_pulses", int'({dir_changed, reject, overflow}), 0);
    // 1: press right, event six edges after the press
    right = 1;
    step(5);
    chk("t1_count_before", int'(queue_count), 0);
    step(1);
    chk("t1_count_at6", int'(queue_count), 1);
    step(4);
    right = 0;
    step(8);
    expect_ev(0, 1);
    pulse_tick();
    chk("t1_dir", int'(dir), 1);
    chk("t1_changed_gone", int'(dir_changed), 0);
    // 2: reversal from TOP
    do_reset();
    expect_ev(1, 0);
    press(4'b0100);
    chk("t2_count", int'(queue_count), 0);
    pulse_tick();
    chk("t2_dir", int'(dir), 0);
    // 3: left then down queued, drained over two ticks
    press(4'b1000);
    press(4'b0100);
    chk("t3_count", int'(queue_count), 2);
    expect_ev(0, 3);
    pulse_tick();
    chk("t3_dir1", int'(dir), 3);
    expect_ev(0, 2);
    pulse_tick();
    chk("t3_dir2", int'(dir), 2);
    // 4: fill queue, fifth accepted press overflows
    do_reset();
    press(4'b0010);
    press(4'b0001);
    press(4'b1000);
    press(4'b0001);
    chk("t4_full", int'(queue_count), 4);
    expect_ev(2, 0);
    press(4'b0010);
    chk("t4_still_full", int'(queue_count), 4);
    expect_ev(0, 1);
    expect_ev(0, 0);
    expect_ev(0, 3);
    expect_ev(0, 0);
    repeat (4) pulse_tick();
    chk("t4_dir", int'(dir), 0);
    chk("t4_empty", int'(queue_count), 0);
    pulse_tick();
    chk("t4_idle_tick_dir", int'(dir), 0);
    // 5: simultaneous up+left is ambiguous; bouncing input never settles
    do_reset();
    expect_ev(1, 0);
    press(4'b1001);
    chk("t5_count", int'(queue_count), 0);
    for (int i = 0; i < 10; i++) begin
      right = ~right;
      step(2);
    end
    right = 0;
    step(8);
    chk("t5_bounce_count", int'(queue_count), 0);
    // 5b: press coinciding with tick is validated against the single queued entry
    press(4'b0010);
    expect_ev(0, 1);
    down = 1;
    step(5);
    tick = 1;
    step(1);
    tick = 0;
    chk("t5b_count", int'(queue_count), 1);
    chk("t5b_dir", int'(dir), 1);
    step(4);
    down = 0;
    step(8);
    expect_ev(0, 2);
    pulse_tick();
    chk("t5b_dir2", int'(dir), 2);
    // 6: reset mid-operation flushes queue
    do_reset();
    press(4'b0010);
    press(4'b0001);
    press(4'b1000);
    chk("t6_count3", int'(queue_count), 3);
    reset = 1;
    step(1);
    reset = 0;
    chk("t6_count0", int'(queue_count), 0);
    chk("t6_dir", int'(dir), 0);
    step(1);
    chk("t6_no_pulse", int'({dir_changed, reject, overflow}), 0);
    pulse_tick();
    pulse_tick();
    chk("t6_dir_after_ticks", int'(dir), 0);
    step(5);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
